// File: rtl/fifo_srl_p.sv
// Shift-register FIFO with occupancy count, level flags, and sticky
// overflow/underflow flags. The output stage is either first-word fall-through
// (OREG=0) or registered (OREG=1).
module fifo_srl_p #(
  parameter int WIDTH  = 9,
  parameter int DEPTH  = 32,
  parameter int AF_LVL = DEPTH - 2,
  parameter int AE_LVL = 1,
  parameter int OREG   = 0,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [WIDTH-1:0] pdi,
  input  logic             iv,
  input  logic             oe,
  output logic [WIDTH-1:0] pdo,
  output logic             ov,
  output logic             empty,
  output logic             full,
  output logic             afull,
  output logic             aempty,
  output logic [CW-1:0]    count,
  output logic             ovf,
  output logic             udf
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             we;
  logic             re;
  logic [AW-1:0]    head_idx;
  logic [WIDTH-1:0] head;

  assign we = iv & ~full;
  assign re = oe & ~empty;

  // The oldest entry sits at count-1. At count=DEPTH the low bits wrap to 0,
  // and subtracting 1 then gives DEPTH-1, which is the correct slot.
  assign head_idx = count[AW-1:0] - AW'(1);
  assign head     = mem[head_idx];

  // Flags decode straight from the registered count, so they move in the same cycle as count.
  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign afull  = (count >= CW'(AF_LVL));
  assign aempty = (count <= CW'(AE_LVL));

  // Storage: a write shifts every entry up by one. There is no reset, so this maps onto SRL primitives.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[0] <= pdi;
      for (int k = 1; k < DEPTH; k++) begin
        mem[k] <= mem[k-1];
      end
    end
  end

  // Occupancy counter. A flush takes priority over any accepted read or write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (we && !re) begin
      count <= count + CW'(1);
    end else if (re && !we) begin
      count <= count - CW'(1);
    end
  end

  // Sticky error flags. They record requests made against a full or empty FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else if (clr) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (iv && full)  ovf <= 1'b1;
      if (oe && empty) udf <= 1'b1;
    end
  end

  generate
    if (OREG != 0) begin : g_oreg
      logic [WIDTH-1:0] pdo_q;
      logic             ov_q;

      // Registered output stage: capture the head on a read and hold it otherwise.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pdo_q <= '0;
          ov_q  <= 1'b0;
        end else begin
          ov_q <= re & ~clr;
          if (re && !clr) pdo_q <= head;
        end
      end

      assign pdo = pdo_q;
      assign ov  = ov_q;
    end else begin : g_comb
      assign pdo = head;
      assign ov  = re;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_srl_p.sv
// Bench for fifo_srl_p. It runs four instances from one shared stimulus:
//   u0: the defaults (32x9, OREG=0)
//   u1: 32x9 with OREG=1
//   u2: 4x1
//   u3: 256x64
// Each depth has its own queue model. The models are checked every cycle, and
// directed literal expectations pin them.
module tb_fifo_srl_p;

  logic        clk = 1'b0;
  logic        rst_n, clr, iv, oe;
  logic [63:0] pdi;
  logic        cmp_on = 1'b0;
  int          checks = 0;
  int          failures = 0;

  logic [8:0]  pdo0, pdo1;
  logic [0:0]  pdo2;
  logic [63:0] pdo3;
  logic        ov0, empty0, full0, afull0, aempty0, ovf0, udf0;
  logic        ov1, empty1, full1, afull1, aempty1, ovf1, udf1;
  logic        ov2, empty2, full2, afull2, aempty2, ovf2, udf2;
  logic        ov3, empty3, full3, afull3, aempty3, ovf3, udf3;
  logic [5:0]  count0, count1;
  logic [2:0]  count2;
  logic [8:0]  count3;

  always #5 clk = ~clk;

  fifo_srl_p u0 (.clk(clk), .rst_n(rst_n), .clr(clr), .pdi(pdi[8:0]), .iv(iv), .oe(oe),
    .pdo(pdo0), .ov(ov0), .empty(empty0), .full(full0), .afull(afull0), .aempty(aempty0),
    .count(count0), .ovf(ovf0), .udf(udf0));
  fifo_srl_p #(.OREG(1)) u1 (.clk(clk), .rst_n(rst_n), .clr(clr), .pdi(pdi[8:0]), .iv(iv), .oe(oe),
    .pdo(pdo1), .ov(ov1), .empty(empty1), .full(full1), .afull(afull1), .aempty(aempty1),
    .count(count1), .ovf(ovf1), .udf(udf1));
  fifo_srl_p #(.DEPTH(4), .WIDTH(1)) u2 (.clk(clk), .rst_n(rst_n), .clr(clr), .pdi(pdi[0:0]), .iv(iv), .oe(oe),
    .pdo(pdo2), .ov(ov2), .empty(empty2), .full(full2), .afull(afull2), .aempty(aempty2),
    .count(count2), .ovf(ovf2), .udf(udf2));
  fifo_srl_p #(.DEPTH(256), .WIDTH(64)) u3 (.clk(clk), .rst_n(rst_n), .clr(clr), .pdi(pdi), .iv(iv), .oe(oe),
    .pdo(pdo3), .ov(ov3), .empty(empty3), .full(full3), .afull(afull3), .aempty(aempty3),
    .count(count3), .ovf(ovf3), .udf(udf3));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference models: a queue per depth plus sticky flags, with oldest at [0].
  logic [63:0] q0[$], q2[$], q3[$];
  logic        movf0, mudf0, movf2, mudf2, movf3, mudf3;
  logic        mov1;
  logic [8:0]  mpdo1;
  logic [63:0] tmp;
  logic        w, r;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q0.delete(); q2.delete(); q3.delete();
      movf0 = 0; mudf0 = 0; movf2 = 0; mudf2 = 0; movf3 = 0; mudf3 = 0;
      mov1 = 0; mpdo1 = '0;
    end else if (clr) begin
      q0.delete(); q2.delete(); q3.delete();
      movf0 = 0; mudf0 = 0; movf2 = 0; mudf2 = 0; movf3 = 0; mudf3 = 0;
      mov1 = 0;
    end else begin
      mov1 = oe && q0.size() > 0;
      if (mov1) begin tmp = q0[0]; mpdo1 = tmp[8:0]; end
      if (iv && q0.size() == 32) movf0 = 1;
      if (oe && q0.size() == 0)  mudf0 = 1;
      w = iv && q0.size() < 32; r = oe && q0.size() > 0;
      if (r) void'(q0.pop_front());
      if (w) q0.push_back(pdi & 64'h1FF);

      if (iv && q2.size() == 4) movf2 = 1;
      if (oe && q2.size() == 0) mudf2 = 1;
      w = iv && q2.size() < 4; r = oe && q2.size() > 0;
      if (r) void'(q2.pop_front());
      if (w) q2.push_back(pdi & 64'h1);

      if (iv && q3.size() == 256) movf3 = 1;
      if (oe && q3.size() == 0)   mudf3 = 1;
      w = iv && q3.size() < 256; r = oe && q3.size() > 0;
      if (r) void'(q3.pop_front());
      if (w) q3.push_back(pdi);
    end
  end

  // Compare all instances against the models, away from the active edge.
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("count0", count0, q0.size());
      chk("empty0", empty0, q0.size() == 0);
      chk("full0", full0, q0.size() == 32);
      chk("afull0", afull0, q0.size() >= 30);
      chk("aempty0", aempty0, q0.size() <= 1);
      chk("ovf0", ovf0, movf0);
      chk("udf0", udf0, mudf0);
      chk("ov0", ov0, oe && q0.size() > 0);
      if (q0.size() > 0) chk("pdo0", pdo0, q0[0]);

      chk("count1", count1, q0.size());
      chk("flags1", {empty1, full1, afull1, aempty1, ovf1, udf1},
          {q0.size() == 0, q0.size() == 32, q0.size() >= 30, q0.size() <= 1, movf0, mudf0});
      chk("ov1", ov1, mov1);
      chk("pdo1", pdo1, mpdo1);

      chk("count2", count2, q2.size());
      chk("range2", count2 <= 3'd4, 1'b1);
      chk("flags2", {empty2, full2, afull2, aempty2, ovf2, udf2},
          {q2.size() == 0, q2.size() == 4, q2.size() >= 2, q2.size() <= 1, movf2, mudf2});
      chk("ov2", ov2, oe && q2.size() > 0);
      if (q2.size() > 0) chk("pdo2", pdo2, q2[0]);

      chk("count3", count3, q3.size());
      chk("range3", count3 <= 9'd256, 1'b1);
      chk("flags3", {empty3, full3, afull3, aempty3, ovf3, udf3},
          {q3.size() == 0, q3.size() == 256, q3.size() >= 254, q3.size() <= 1, movf3, mudf3});
      chk("ov3", ov3, oe && q3.size() > 0);
      if (q3.size() > 0) chk("pdo3", pdo3, q3[0]);
    end
  end

  int piv[3] = '{90, 20, 50};
  int poe[3] = '{25, 85, 50};

  initial begin
    rst_n = 0; clr = 0; iv = 0; oe = 0; pdi = '0;
    repeat (2) tick();
    cmp_on = 1;
    chk("rst_count", count0, 0);
    chk("rst_empty", empty0, 1);
    chk("rst_aempty", aempty0, 1);
    chk("rst_afull", afull0, 0);
    chk("rst_ov1", ov1, 0);
    chk("rst_pdo1", pdo1, 0);
    rst_n = 1;

    // Fill 0..31, then drain in order.
    for (int i = 0; i < 32; i++) begin
      iv = 1; pdi = i; tick();
      chk("fill_afull", afull0, (i + 1) >= 30);
    end
    iv = 0;
    chk("fill_count", count0, 32);
    chk("fill_full", full0, 1);
    oe = 1;
    for (int i = 0; i < 32; i++) begin
      #1;
      chk("drain_pdo", pdo0, i);
      chk("drain_ov", ov0, 1);
      tick();
    end
    oe = 0;
    chk("drain_empty", empty0, 1);

    // Overflow, underflow, flush.
    for (int i = 0; i < 33; i++) begin iv = 1; pdi = 64 + i; tick(); end
    iv = 0;
    chk("ovf_set", ovf0, 1);
    chk("ovf_count", count0, 32);
    oe = 1;
    repeat (32) tick();
    #1 chk("udf_ov", ov0, 0);
    tick();
    oe = 0;
    chk("udf_set", udf0, 1);
    clr = 1; tick(); clr = 0;
    chk("clr_ovf", ovf0, 0);
    chk("clr_udf", udf0, 0);
    chk("clr_count", count0, 0);

    // Simultaneous read and write at count 5.
    for (int i = 0; i < 5; i++) begin iv = 1; pdi = 100 + i; tick(); end
    for (int k = 0; k < 10; k++) begin
      iv = 1; oe = 1; pdi = 200 + k;
      #1 chk("sim_pdo", pdo0, (k < 5) ? 100 + k : 200 + k - 5);
      tick();
      chk("sim_count", count0, 5);
    end
    iv = 0; oe = 0; clr = 1; tick(); clr = 0;

    // Simultaneous read and write while empty.
    iv = 1; oe = 1; pdi = 7;
    #1 chk("sime_ov", ov0, 0);
    tick();
    iv = 0; oe = 0;
    chk("sime_count", count0, 1);
    chk("sime_udf", udf0, 1);
    clr = 1; tick(); clr = 0;

    // Simultaneous read and write while full.
    for (int i = 0; i < 32; i++) begin iv = 1; pdi = i; tick(); end
    iv = 1; oe = 1; pdi = 9'h155;
    #1 chk("simf_pdo", pdo0, 0);
    tick();
    iv = 0; oe = 0;
    chk("simf_count", count0, 31);
    chk("simf_ovf", ovf0, 1);
    clr = 1; tick(); clr = 0;

    // Registered output latency.
    iv = 1; pdi = 64'hA5; tick(); iv = 0;
    oe = 1;
    #1 chk("oreg_ov_early", ov1, 0);
    tick(); oe = 0;
    chk("oreg_ov", ov1, 1);
    chk("oreg_pdo", pdo1, 9'hA5);
    tick();
    chk("oreg_ov_fall", ov1, 0);
    chk("oreg_pdo_hold", pdo1, 9'hA5);

    // Asynchronous reset between edges at count 17.
    for (int i = 0; i < 17; i++) begin iv = 1; pdi = 300 + i; tick(); end
    iv = 0;
    chk("pre_rst_count", count0, 17);
    #2 rst_n = 0;
    #1;
    chk("arst_count", count0, 0);
    chk("arst_empty", empty0, 1);
    chk("arst_ov1", ov1, 0);
    chk("arst_pdo1", pdo1, 0);
    tick();
    rst_n = 1; iv = 1; pdi = 64'h1FF; tick(); iv = 0;
    chk("post_count", count0, 1);
    chk("post_pdo", pdo0, 9'h1FF);

    // Random traffic, biased to reach full and empty on every depth.
    for (int ph = 0; ph < 3; ph++) begin
      for (int c = 0; c < 1200; c++) begin
        iv  = $urandom_range(99) < piv[ph];
        oe  = $urandom_range(99) < poe[ph];
        clr = (ph == 2) && ($urandom_range(299) == 0);
        pdi = {$urandom, $urandom};
        tick();
      end
    end
    iv = 0; oe = 0; clr = 0;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_srl_p.md
FIFO_SRL_P -- requirements
Module: fifo_srl_p

Interface
REQ-001 Parameter WIDTH, default 9: data width in bits, range 1..64.
REQ-002 Parameter DEPTH, default 32: storage entries, a power of 2 in the range 4..256; capacity is DEPTH entries.
REQ-003 Parameter AF_LVL, default DEPTH-2: almost-full threshold, in entries.
REQ-004 Parameter AE_LVL, default 1: almost-empty threshold, in entries.
REQ-005 Parameter OREG, default 0: 0 = combinational head output, 1 = registered output stage.
REQ-006 Derived CW = clog2(DEPTH+1): width of the occupancy count.
REQ-007 clk  in  1: single clock; all state changes on its rising edge.
REQ-008 rst_n  in  1: reset, asynchronous and active-low.
REQ-009 clr  in  1: synchronous flush, active-high.
REQ-010 pdi  in  WIDTH: write data.
REQ-011 iv  in  1: input valid, i.e. the write request.
REQ-012 oe  in  1: output enable, i.e. the read request.
REQ-013 pdo  out  WIDTH: read data.
REQ-014 ov  out  1: output valid; a read was accepted (OREG=0) or pdo is valid (OREG=1).
REQ-015 empty  out  1: occupancy is 0.
REQ-016 full  out  1: occupancy is DEPTH.
REQ-017 afull  out  1: occupancy >= AF_LVL.
REQ-018 aempty  out  1: occupancy <= AE_LVL.
REQ-019 count  out  CW: current occupancy.
REQ-020 ovf  out  1: sticky overflow flag.
REQ-021 udf  out  1: sticky underflow flag.

Function
REQ-022 Write accept: we = iv & ~full. Read accept: re = oe & ~empty.
REQ-023 Storage SHALL be a shift register with no reset: on we, pdi enters entry 0 and entry k moves to k+1.
REQ-024 The head (oldest entry) SHALL be at index count-1.
REQ-025 count update per cycle: +1 on we&~re; -1 on re&~we; unchanged on we&re or when neither is accepted.
REQ-026 When empty and both iv and oe are high: write accepted, read rejected, count goes to 1, udf is set.
REQ-027 When full and both iv and oe are high: read accepted, write rejected, count goes to DEPTH-1, ovf is set.
REQ-028 All flags SHALL be decoded from the registered count, so they are valid in the same cycle count changes.
REQ-029 ovf SHALL set on iv&full; udf SHALL set on oe&empty; both hold until clr or reset.
REQ-030 OREG=0: pdo = head entry combinationally (first-word fall-through); ov = re combinationally.
REQ-031 OREG=0: pdo is undefined while empty.
REQ-032 OREG=1: on re, pdo registers the head and ov is 1 in the following cycle; ov is 0 after any cycle without re.
REQ-033 OREG=1: pdo holds its last value when ov=0.
REQ-034 clr SHALL set count, ovf, udf and registered ov to 0 on the next edge, overriding we/re in that cycle.
REQ-035 When clr is asserted, storage contents are don't-care; a simultaneous write is discarded.
REQ-036 With DEPTH=32, WIDTH=9, OREG=0: behaviour is cycle-identical to the existing 9-bit SRL FIFO, except that capacity is 32 rather than 31 and the added outputs are present.

Reset
REQ-037 While rst_n=0, asynchronously: count=0, empty=1, full=0, aempty=1, afull=0 (AF_LVL>0), ovf=0, udf=0, ov=0.
REQ-038 While rst_n=0 with OREG=1: pdo=0.
REQ-039 Storage SHALL NOT be reset; after reset, data is defined only once it has been written.
REQ-040 Reset deassertion SHALL be synchronised externally; the first accepted operation is on the first edge after rst_n rises.
REQ-041 Reset asserted mid-operation discards all contents; no spurious ov is produced.

Verification
REQ-042 Fill/drain (DEPTH=32, OREG=0): write 0..31 with iv held high; expected full=1, count=32, afull asserted at count 30; then read 32 times, expected pdo = 0,1,...,31 in order and empty=1 at the end.
REQ-043 Overflow/underflow: write 33 words into DEPTH=32, expected ovf=1 and count=32. Assert oe for 1 cycle when empty, expected udf=1 and ov=0. Pulse clr, expected ovf=udf=0 and count=0.
REQ-044 Simultaneous: at count=5, assert iv and oe together for 10 cycles, expected count stays 5 and output order preserved. Repeat at empty: expected count becomes 1 and udf=1. Repeat at full: expected count becomes 31 and ovf=1.
REQ-045 OREG=1 latency: write 0xA5 then assert oe, expected ov=1 and pdo=0xA5 exactly one cycle later; pdo holds 0xA5 after ov falls.
REQ-046 Async reset: drop rst_n between clock edges at count=17, expected count=0 and empty=1 immediately. After release, write 0x1FF, expected count=1 and pdo=0x1FF (OREG=0).
REQ-047 Parameter sweep: DEPTH in {4,256} and WIDTH in {1,64}, random iv/oe against a reference queue model: no data mismatch, and count never leaves the range 0..DEPTH.
